rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter TAG_WIDTH, default 3, writer-tag width; 2^TAG_WIDTH SHALL exceed the number of in-flight writers, which is a pipeline integration rule.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NUM_FWD, default 2, number of forwarding channels, index 0 youngest.
REQ-005 SHALL have ports, each listed as name, direction, width, meaning:
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*5  per-port register index.
- rd_data  out  NUM_RD*XLEN  per-port operand.
- rd_valid  out  NUM_RD  operand usable this cycle.
- iss_en  in  1  issued instruction writes rd.
- iss_addr  in  5  destination index.
- iss_tag  out  TAG_WIDTH  tag granted to the issuing writer.
- fwd_en  in  NUM_FWD  forwarding channel valid.
- fwd_addr  in  NUM_FWD*5  forwarding destination.
- fwd_tag  in  NUM_FWD*TAG_WIDTH  forwarding writer tag.
- fwd_data  in  NUM_FWD*XLEN  forwarding value.
- wb_en  in  1  writeback valid.
- wb_addr  in  5  writeback index.
- wb_tag  in  TAG_WIDTH  writeback tag.
- wb_data  in  XLEN  writeback value.
- flush  in  1  discard all pending-writer state.

Function
REQ-006 SHALL hold 31 entries (x1..x31), each with XLEN data, a dirty bit and a TAG_WIDTH tag; x0 SHALL read 0 and SHALL never be dirty.
REQ-007 SHALL drive iss_tag combinationally from a tag counter; on iss_en with iss_addr!=0 the entry SHALL take dirty=1 and tag=iss_tag at the next edge, and the counter SHALL increment modulo 2^TAG_WIDTH.
REQ-008 iss_en with iss_addr==0 SHALL change no state, and the counter SHALL hold.
REQ-009 On wb_en, addr!=0 and wb_tag equal to the stored tag, the entry SHALL write wb_data and clear dirty at the next edge; on a tag mismatch the write SHALL be dropped.
REQ-010 On wb and iss to the same address in the same cycle, iss SHALL win: dirty stays 1 with the new tag. Data SHALL still be written if the old tag matched.
REQ-011 Reads SHALL be combinational, zero latency. When the entry is clean: rd_valid=1 and rd_data = the stored data.
REQ-012 When the entry is dirty, sources SHALL be searched in priority order: fwd[0], ..., fwd[NUM_FWD-1], then wb. The first source with en=1, matching addr and tag equal to the stored tag SHALL give rd_valid=1 and its data; with no hit, rd_valid=0 and rd_data=0.
REQ-013 A read with rd_en=0 SHALL output rd_valid=0 and rd_data=0.
REQ-014 A same-cycle iss SHALL NOT affect reads in that cycle; reads see pre-edge state.
REQ-015 flush SHALL clear every dirty bit at the next edge; an iss in the same cycle SHALL still be applied (iss wins), and the counter SHALL NOT reset.
REQ-016 Tag wrap-around (for TAG_WIDTH=3, 7 -> 0) SHALL require no special handling.

Reset
REQ-017 On reset=1 at an edge: all data SHALL be 0, all dirty bits 0, all tags 0, and the tag counter 0; iss/wb/flush SHALL be ignored in that cycle.
REQ-018 After reset every read SHALL return rd_valid=1 and rd_data=0.

Configuration
REQ-019 Macro SCOREBOARD_FWD_EN SHALL control forwarding.
- Defined: REQ-012 applies in full.
- Undefined: fwd_* inputs SHALL be ignored; a dirty entry SHALL be valid only via a same-cycle wb hit; ports SHALL remain present.

Structure
REQ-020 TAG_WIDTH default and the register-index width constant (5) SHALL live in riscv_pkg.
REQ-021 Per-read-port source selection SHALL be a sub-module rf_fwd_mux, instantiated NUM_RD times via generate.

Verification
REQ-022 Reset, then read x5 on port 0 -> rd_valid=1, rd_data=0.
REQ-023 iss x5 (tag 0), next cycle read x5 -> rd_valid=0; then fwd[1] = x5, tag 0, 0x1234 -> rd_valid=1, 0x1234.
REQ-024 iss x7 twice (tags 1, 2), then wb x7 tag 1 0xAA -> dropped, x7 stays dirty; then wb x7 tag 2 0xBB -> x7 clean, reads 0xBB.
REQ-025 fwd[0] and fwd[1] both hit x3 (0x11, 0x22) -> rd_data=0x11.
REQ-026 Same cycle: wb x9 with matching tag and iss x9 -> x9 dirty with the new tag and data updated; iss x0 -> iss_tag unchanged next cycle.
REQ-027 Nine issues wrap the counter 7 -> 0 -> 1; flush with pending x4 -> x4 clean next cycle; build without SCOREBOARD_FWD_EN -> fwd hit ignored, rd_valid=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer register-file constants: index width and default writer-tag width.
// Pure constants, no logic; no handshake.
package riscv_pkg;
    localparam int REG_IDX_W     = 5;
    localparam int NUM_REGS      = 1 << REG_IDX_W;
    localparam int TAG_WIDTH_DEF = 3;
endpackage

// File: rtl/rf_fwd_mux.sv
// Operand source select for one read port: clean entry, else forwarding (SCOREBOARD_FWD_EN) then writeback.
// Purely combinational, zero latency; no backpressure, rd_valid=0 tells the issuer to stall.
module rf_fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int NUM_FWD   = 2
) (
    input  logic                           rd_en,
    input  logic [REG_IDX_W-1:0]           rd_addr,
    input  logic                           ent_dirty,
    input  logic [TAG_WIDTH-1:0]           ent_tag,
    input  logic [XLEN-1:0]                ent_data,
    input  logic [NUM_FWD-1:0]             fwd_en,
    input  logic [NUM_FWD*REG_IDX_W-1:0]   fwd_addr,
    input  logic [NUM_FWD*TAG_WIDTH-1:0]   fwd_tag,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_data,
    input  logic                           wb_en,
    input  logic [REG_IDX_W-1:0]           wb_addr,
    input  logic [TAG_WIDTH-1:0]           wb_tag,
    input  logic [XLEN-1:0]                wb_data,
    output logic                           rd_valid,
    output logic [XLEN-1:0]                rd_data
);

`ifndef SCOREBOARD_FWD_EN
    logic unused_fwd;
    assign unused_fwd = &{1'b0, fwd_en, fwd_addr, fwd_tag, fwd_data};
`endif

    always_comb begin
        rd_valid = 1'b0;
        rd_data  = '0;
        if (rd_en) begin
            if (!ent_dirty) begin
                rd_valid = 1'b1;
                rd_data  = ent_data;
            end else begin
`ifdef SCOREBOARD_FWD_EN
                // Channel 0 is the youngest producer, so the first hit wins.
                for (int j = 0; j < NUM_FWD; j++) begin
                    if (!rd_valid && fwd_en[j]
                        && fwd_addr[j*REG_IDX_W +: REG_IDX_W] == rd_addr
                        && fwd_tag[j*TAG_WIDTH +: TAG_WIDTH] == ent_tag) begin
                        rd_valid = 1'b1;
                        rd_data  = fwd_data[j*XLEN +: XLEN];
                    end
                end
`endif
                if (!rd_valid && wb_en && wb_addr == rd_addr && wb_tag == ent_tag) begin
                    rd_valid = 1'b1;
                    rd_data  = wb_data;
                end
            end
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with per-entry pending-writer tags; reads zero latency, updates at the next edge.
// No backpressure: rd_valid=0 means the operand is not yet available. Forwarding gated by SCOREBOARD_FWD_EN.
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int NUM_RD    = 2,
    parameter int NUM_FWD   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD*REG_IDX_W-1:0]    rd_addr,
    output logic [NUM_RD*XLEN-1:0]         rd_data,
    output logic [NUM_RD-1:0]              rd_valid,
    input  logic                           iss_en,
    input  logic [REG_IDX_W-1:0]           iss_addr,
    output logic [TAG_WIDTH-1:0]           iss_tag,
    input  logic [NUM_FWD-1:0]             fwd_en,
    input  logic [NUM_FWD*REG_IDX_W-1:0]   fwd_addr,
    input  logic [NUM_FWD*TAG_WIDTH-1:0]   fwd_tag,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_data,
    input  logic                           wb_en,
    input  logic [REG_IDX_W-1:0]           wb_addr,
    input  logic [TAG_WIDTH-1:0]           wb_tag,
    input  logic [XLEN-1:0]                wb_data,
    input  logic                           flush
);

    logic [XLEN-1:0]      data_q [NUM_REGS];
    logic [XLEN-1:0]      data_d [NUM_REGS];
    logic [TAG_WIDTH-1:0] tag_q  [NUM_REGS];
    logic [TAG_WIDTH-1:0] tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]  dirty_q, dirty_d;
    logic [TAG_WIDTH-1:0] cnt_q, cnt_d;

    assign iss_tag = cnt_q;

    // Entry 0 is never written, so x0 stays clean and reads zero.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        dirty_d = dirty_q;
        cnt_d   = cnt_q;
        if (flush) begin
            dirty_d = '0;
        end
        if (wb_en && wb_addr != '0 && wb_tag == tag_q[wb_addr]) begin
            data_d[wb_addr]  = wb_data;
            dirty_d[wb_addr] = 1'b0;
        end
        // Issue is applied last so it overrides both writeback and flush.
        if (iss_en && iss_addr != '0) begin
            dirty_d[iss_addr] = 1'b1;
            tag_d[iss_addr]   = cnt_q;
            cnt_d             = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            dirty_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [REG_IDX_W-1:0] addr;
        assign addr = rd_addr[p*REG_IDX_W +: REG_IDX_W];

        rf_fwd_mux #(
            .XLEN      (XLEN),
            .TAG_WIDTH (TAG_WIDTH),
            .NUM_FWD   (NUM_FWD)
        ) u_mux (
            .rd_en     (rd_en[p]),
            .rd_addr   (addr),
            .ent_dirty (dirty_q[addr]),
            .ent_tag   (tag_q[addr]),
            .ent_data  (data_q[addr]),
            .fwd_en    (fwd_en),
            .fwd_addr  (fwd_addr),
            .fwd_tag   (fwd_tag),
            .fwd_data  (fwd_data),
            .wb_en     (wb_en),
            .wb_addr   (wb_addr),
            .wb_tag    (wb_tag),
            .wb_data   (wb_data),
            .rd_valid  (rd_valid[p]),
            .rd_data   (rd_data[p*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed scenarios followed by random traffic, checked against an array-based register-file model.
module tb_rf_scoreboard;
    localparam int XLEN = 32;
    localparam int TW   = 3;
    localparam int NRD  = 2;
    localparam int NFWD = 2;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD-1:0]       rd_en;
    logic [NRD*5-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_valid;
    logic                 iss_en;
    logic [4:0]           iss_addr;
    logic [TW-1:0]        iss_tag;
    logic [NFWD-1:0]      fwd_en;
    logic [NFWD*5-1:0]    fwd_addr;
    logic [NFWD*TW-1:0]   fwd_tag;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [TW-1:0]        wb_tag;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;

    always #5 clk = ~clk;

    rf_scoreboard #(.XLEN(XLEN), .TAG_WIDTH(TW), .NUM_RD(NRD), .NUM_FWD(NFWD)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data), .flush(flush)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [XLEN-1:0] m_data  [32];
    bit              m_dirty [32];
    int              m_tag   [32];
    int              m_cnt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // Expected operand for port p from the model and the current inputs.
    function automatic void mread(input int p, output bit v, output logic [XLEN-1:0] d);
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        v = 1'b0;
        d = '0;
        if (!rd_en[p]) return;
        if (a == 0) begin
            v = 1'b1;
            return;
        end
        if (!m_dirty[a]) begin
            v = 1'b1;
            d = m_data[a];
            return;
        end
        if (FWD_ON) begin
            for (int j = 0; j < NFWD; j++) begin
                if (!v && fwd_en[j] && fwd_addr[j*5 +: 5] == a && int'(fwd_tag[j*TW +: TW]) == m_tag[a]) begin
                    v = 1'b1;
                    d = fwd_data[j*XLEN +: XLEN];
                end
            end
        end
        if (!v && wb_en && wb_addr == a && int'(wb_tag) == m_tag[a]) begin
            v = 1'b1;
            d = wb_data;
        end
    endfunction

    task automatic mupdate();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i]  = '0;
                m_dirty[i] = 1'b0;
                m_tag[i]   = 0;
            end
            m_cnt = 0;
        end else begin
            if (flush)
                for (int i = 0; i < 32; i++) m_dirty[i] = 1'b0;
            if (wb_en && wb_addr != 0 && int'(wb_tag) == m_tag[wb_addr]) begin
                m_data[wb_addr]  = wb_data;
                m_dirty[wb_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) begin
                m_dirty[iss_addr] = 1'b1;
                m_tag[iss_addr]   = m_cnt;
                m_cnt             = (m_cnt + 1) % (1 << TW);
            end
        end
    endtask

    // Called just after a negedge with inputs set: check outputs, clock once, advance the model.
    task automatic step();
        bit v;
        logic [XLEN-1:0] d;
        #1;
        for (int p = 0; p < NRD; p++) begin
            mread(p, v, d);
            chk($sformatf("rd%0d_valid", p), rd_valid[p], v);
            chk($sformatf("rd%0d_data", p), rd_data[p*XLEN +: XLEN], d);
        end
        chk("iss_tag", iss_tag, m_cnt);
        @(posedge clk);
        mupdate();
        @(negedge clk);
    endtask

    task automatic set_rd(input int p, input bit en, input int a);
        rd_en[p]        = en;
        rd_addr[p*5 +: 5] = a[4:0];
    endtask

    task automatic quiet();
        reset  = 1'b0;
        flush  = 1'b0;
        iss_en = 1'b0;
        wb_en  = 1'b0;
        fwd_en = '0;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; iss_en = 1'b0; iss_addr = '0;
        rd_en = '0; rd_addr = '0; fwd_en = '0; fwd_addr = '0; fwd_tag = '0; fwd_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_tag = '0; wb_data = '0;
        @(posedge clk);
        mupdate();
        @(negedge clk);
        quiet();

        // Reset state
        set_rd(0, 1, 5); set_rd(1, 1, 0);
        #1 chk("rst_x5_valid", rd_valid[0], 1);
        chk("rst_x5_data", rd_data[XLEN-1:0], 0);
        step();

        // Pending x5, then forwarding on channel 1
        iss_en = 1; iss_addr = 5; step(); quiet();
        #1 chk("x5_pending_valid", rd_valid[0], 0);
        step();
        fwd_en = 2'b10; fwd_addr[9:5] = 5; fwd_tag[5:3] = 0; fwd_data[63:32] = 32'h1234;
        #1 chk("fwd1_x5_valid", rd_valid[0], FWD_ON);
        chk("fwd1_x5_data", rd_data[XLEN-1:0], FWD_ON ? 32'h1234 : 32'h0);
        step(); quiet();

        // Stale writeback dropped, current one lands
        iss_en = 1; iss_addr = 7; step(); step(); quiet();
        set_rd(0, 1, 7);
        wb_en = 1; wb_addr = 7; wb_tag = 1; wb_data = 32'hAA; step(); quiet();
        #1 chk("x7_stale_wb_valid", rd_valid[0], 0);
        step();
        wb_en = 1; wb_addr = 7; wb_tag = 2; wb_data = 32'hBB; step(); quiet();
        #1 chk("x7_clean_valid", rd_valid[0], 1);
        chk("x7_clean_data", rd_data[XLEN-1:0], 32'hBB);
        step();

        // Youngest forwarding channel wins
        iss_en = 1; iss_addr = 3; step(); quiet();
        set_rd(0, 1, 3);
        fwd_en = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_tag = {3'd3, 3'd3}; fwd_data = {32'h22, 32'h11};
        #1 chk("fwd_prio_data", rd_data[XLEN-1:0], FWD_ON ? 32'h11 : 32'h0);
        step(); quiet();

        // Writeback and issue to x9 together, x0 issue, flush exposes written data
        iss_en = 1; iss_addr = 9; step(); quiet();
        wb_en = 1; wb_addr = 9; wb_tag = 4; wb_data = 32'h99; iss_en = 1; iss_addr = 9; step(); quiet();
        set_rd(0, 1, 9);
        #1 chk("x9_reissued_valid", rd_valid[0], 0);
        step();
        iss_en = 1; iss_addr = 0; step(); quiet();
        #1 chk("iss_x0_tag_hold", iss_tag, 6);
        step();
        flush = 1; step(); quiet();
        #1 chk("x9_after_flush_valid", rd_valid[0], 1);
        chk("x9_after_flush_data", rd_data[XLEN-1:0], 32'h99);
        step();

        // Counter wrap over nine issues, then flush pending x4
        reset = 1; step(); quiet();
        for (int k = 0; k < 9; k++) begin
            iss_en = 1; iss_addr = (k == 0) ? 5'd4 : 5'(10 + k);
            step();
        end
        quiet();
        set_rd(0, 1, 4);
        #1 chk("wrap_counter", iss_tag, 1);
        chk("x4_pending_valid", rd_valid[0], 0);
        step();
        flush = 1; step(); quiet();
        #1 chk("x4_flushed_valid", rd_valid[0], 1);
        step();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            iss_en   = $urandom_range(0, 1);
            iss_addr = raddr();
            wb_en    = $urandom_range(0, 1);
            wb_addr  = raddr();
            wb_tag   = ($urandom_range(0, 3) != 0) ? TW'(m_tag[wb_addr]) : TW'($urandom);
            wb_data  = $urandom;
            for (int j = 0; j < NFWD; j++) begin
                logic [4:0] fa;
                fa = raddr();
                fwd_en[j]             = $urandom_range(0, 1);
                fwd_addr[j*5 +: 5]    = fa;
                fwd_tag[j*TW +: TW]   = ($urandom_range(0, 3) != 0) ? TW'(m_tag[fa]) : TW'($urandom);
                fwd_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 7) != 0, int'(raddr()));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
